fp_add_align: RTL and testbench

//  Front end of the single-precision FP adder: the pre-alignment stage that feeds the exponent-update/normalise stage.

---
 rtl/fp_add_pkg.sv | 60 ++++++
 rtl/fp_rshift_sticky.sv | 28 ++
 rtl/fp_add_align.sv | 109 ++++++++++
 tb/tb_fp_add_align.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/fp_add_pkg.sv
// Shared constants and types for the single-precision FP adder pipeline.
// Used by the alignment, exponent-update and rounding stages.
package fp_add_pkg;

  localparam int unsigned EXP_W   = 8;
  localparam int unsigned FRAC_W  = 23;
  localparam int unsigned MANT_W  = 1 + FRAC_W + 3;
  localparam int unsigned SHAMT_W = 5;

  localparam int unsigned      EXP_BIAS = 127;
  localparam logic [EXP_W-1:0] EXP_MAX  = 8'hFF;
  localparam logic [31:0]      QNAN     = 32'h7FC0_0000;

  typedef struct packed {
    logic              sign;
    logic [EXP_W-1:0]  eff_exp;
    logic [MANT_W-1:0] mant;
    logic              is_nan;
    logic              is_inf;
  } fp_unpacked_t;

  typedef struct packed {
    logic [EXP_W-1:0]   exp_max;
    logic [MANT_W-1:0]  mant_big;
    logic [MANT_W-1:0]  mant_small_raw;
    logic [SHAMT_W-1:0] shamt;
    logic               sign_big;
    logic               eff_sub;
    logic               swapped;
    logic               nan_flag;
    logic               inf_flag;
  } align_s1_t;

  typedef struct packed {
    logic [EXP_W-1:0]  exp_max;
    logic [MANT_W-1:0] mant_big;
    logic [MANT_W-1:0] mant_small;
    logic              sign_big;
    logic              eff_sub;
    logic              swapped;
    logic              nan_flag;
    logic              inf_flag;
  } align_out_t;

  // Denormals and zero take effective exponent 1 with no hidden bit.
  function automatic fp_unpacked_t fp_unpack(input logic [31:0] v, input logic flip_sign);
    fp_unpacked_t u;
    logic [EXP_W-1:0]  e;
    logic [FRAC_W-1:0] f;
    e         = v[FRAC_W +: EXP_W];
    f         = v[FRAC_W-1:0];
    u.sign    = v[31] ^ flip_sign;
    u.eff_exp = (e == '0) ? EXP_W'(1) : e;
    u.mant    = {(e != '0), f, 3'b000};
    u.is_nan  = (e == EXP_MAX) && (f != '0);
    u.is_inf  = (e == EXP_MAX) && (f == '0);
    return u;
  endfunction

endpackage

// File: rtl/fp_rshift_sticky.sv
// Combinational logarithmic right shifter; bits shifted out are OR-ed into bit 0.
module fp_rshift_sticky
  import fp_add_pkg::*;
(
  input  logic [MANT_W-1:0]  i_data,
  input  logic [SHAMT_W-1:0] i_shamt,
  output logic [MANT_W-1:0]  o_data
);

  logic [MANT_W-1:0] w_val;
  logic [MANT_W-1:0] w_mask;
  logic              w_sticky;

  always_comb begin
    w_val    = i_data;
    w_mask   = '0;
    w_sticky = 1'b0;
    for (int k = 0; k < int'(SHAMT_W); k++) begin
      if (i_shamt[k]) begin
        w_mask   = ~({MANT_W{1'b1}} << (1 << k));
        w_sticky = w_sticky | (|(w_val & w_mask));
        w_val    = w_val >> (1 << k);
      end
    end
    o_data = {w_val[MANT_W-1:1], w_val[0] | w_sticky};
  end

endmodule

// File: rtl/fp_add_align.sv
// FP adder pre-alignment: unpack/classify/swap in stage 1, sticky right shift in stage 2.
// Both stages are registered with a valid/ready handshake and no skid buffer.
module fp_add_align
  import fp_add_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       op_a,
  input  logic [31:0]       op_b,
  input  logic              sub,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [EXP_W-1:0]  exp_max,
  output logic [MANT_W-1:0] mant_big,
  output logic [MANT_W-1:0] mant_small,
  output logic              sign_big,
  output logic              eff_sub,
  output logic              swapped,
  output logic              nan_flag,
  output logic              inf_flag
);

  fp_unpacked_t       w_ua, w_ub, w_big, w_small;
  logic               w_swap;
  logic [EXP_W:0]     w_diff;
  logic [SHAMT_W-1:0] w_shamt;
  align_s1_t          w_s1_d;
  logic [MANT_W-1:0]  w_mant_small_sh;
  logic               w_s2_adv;

  logic       r_s1_valid;
  align_s1_t  r_s1;
  logic       r_out_valid;
  align_out_t r_out;

  always_comb begin
    w_ua    = fp_unpack(op_a, 1'b0);
    w_ub    = fp_unpack(op_b, sub);
    // Ties keep A first.
    w_swap  = {w_ub.eff_exp, op_b[FRAC_W-1:0]} > {w_ua.eff_exp, op_a[FRAC_W-1:0]};
    w_big   = w_swap ? w_ub : w_ua;
    w_small = w_swap ? w_ua : w_ub;
    w_diff  = {1'b0, w_big.eff_exp} - {1'b0, w_small.eff_exp};
    w_shamt = (w_diff >= (EXP_W+1)'(MANT_W)) ? SHAMT_W'(MANT_W) : w_diff[SHAMT_W-1:0];

    w_s1_d                = '0;
    w_s1_d.exp_max        = w_big.eff_exp;
    w_s1_d.mant_big       = w_big.mant;
    w_s1_d.mant_small_raw = w_small.mant;
    w_s1_d.shamt          = w_shamt;
    w_s1_d.sign_big       = w_big.sign;
    w_s1_d.eff_sub        = w_ua.sign ^ w_ub.sign;
    w_s1_d.swapped        = w_swap;
    w_s1_d.nan_flag       = w_ua.is_nan | w_ub.is_nan |
                            (w_ua.is_inf & w_ub.is_inf & (w_ua.sign ^ w_ub.sign));
    w_s1_d.inf_flag       = (w_ua.is_inf | w_ub.is_inf) & ~w_s1_d.nan_flag;
  end

  assign w_s2_adv = !r_out_valid || out_ready;
  assign in_ready = !r_s1_valid || w_s2_adv;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_valid <= 1'b0;
      r_s1       <= '0;
    end else if (in_ready) begin
      r_s1_valid <= in_valid;
      if (in_valid) r_s1 <= w_s1_d;
    end
  end

  fp_rshift_sticky u_rshift (
    .i_data  (r_s1.mant_small_raw),
    .i_shamt (r_s1.shamt),
    .o_data  (w_mant_small_sh)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_out       <= '0;
    end else if (w_s2_adv) begin
      r_out_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_out.exp_max    <= r_s1.exp_max;
        r_out.mant_big   <= r_s1.mant_big;
        r_out.mant_small <= w_mant_small_sh;
        r_out.sign_big   <= r_s1.sign_big;
        r_out.eff_sub    <= r_s1.eff_sub;
        r_out.swapped    <= r_s1.swapped;
        r_out.nan_flag   <= r_s1.nan_flag;
        r_out.inf_flag   <= r_s1.inf_flag;
      end
    end
  end

  assign out_valid  = r_out_valid;
  assign exp_max    = r_out.exp_max;
  assign mant_big   = r_out.mant_big;
  assign mant_small = r_out.mant_small;
  assign sign_big   = r_out.sign_big;
  assign eff_sub    = r_out.eff_sub;
  assign swapped    = r_out.swapped;
  assign nan_flag   = r_out.nan_flag;
  assign inf_flag   = r_out.inf_flag;

endmodule

// File: tb/tb_fp_add_align.sv
// Directed-vector bench for fp_add_align: alignment values, flags, backpressure and reset.
module tb_fp_add_align;
  import fp_add_pkg::*;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              in_valid;
  logic              in_ready;
  logic [31:0]       op_a, op_b;
  logic              sub;
  logic              out_valid;
  logic              out_ready;
  logic [EXP_W-1:0]  exp_max;
  logic [MANT_W-1:0] mant_big, mant_small;
  logic              sign_big, eff_sub, swapped, nan_flag, inf_flag;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  fp_add_align dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .op_a       (op_a),
    .op_b       (op_b),
    .sub        (sub),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .exp_max    (exp_max),
    .mant_big   (mant_big),
    .mant_small (mant_small),
    .sign_big   (sign_big),
    .eff_sub    (eff_sub),
    .swapped    (swapped),
    .nan_flag   (nan_flag),
    .inf_flag   (inf_flag)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_cmp++;
    if (obs !== exp_v) begin
      n_err++;
      $display("FAIL %s: got %h want %h", tag, obs, exp_v);
    end
  endtask

  task automatic check_out(input string tag, input logic [7:0] e_exp, input logic [26:0] e_big,
                           input logic [26:0] e_small, input logic e_sign, input logic e_eff,
                           input logic e_sw, input logic e_nan, input logic e_inf);
    check({tag, ".exp_max"},    32'(exp_max),    32'(e_exp));
    check({tag, ".mant_big"},   32'(mant_big),   32'(e_big));
    check({tag, ".mant_small"}, 32'(mant_small), 32'(e_small));
    check({tag, ".sign_big"},   32'(sign_big),   32'(e_sign));
    check({tag, ".eff_sub"},    32'(eff_sub),    32'(e_eff));
    check({tag, ".swapped"},    32'(swapped),    32'(e_sw));
    check({tag, ".nan"},        32'(nan_flag),   32'(e_nan));
    check({tag, ".inf"},        32'(inf_flag),   32'(e_inf));
  endtask

  // Single transfer into an empty pipe; leaves outputs sampled on the negedge out_valid rises.
  task automatic run_one(input string tag, input logic [31:0] a, input logic [31:0] b,
                         input logic s);
    int cnt;
    @(negedge clk);
    out_ready = 1'b1;
    op_a = a; op_b = b; sub = s; in_valid = 1'b1;
    check({tag, ".in_ready"}, 32'(in_ready), 32'd1);
    @(posedge clk);
    #1 in_valid = 1'b0;
    cnt = 0;
    while (cnt < 10) begin
      @(negedge clk);
      cnt++;
      if (out_valid) break;
    end
    check({tag, ".latency"}, cnt, 32'd2);
  endtask

  logic [31:0] str_a   [4] = '{32'h3F80_0000, 32'h4000_0000, 32'h4080_0000, 32'h4100_0000};
  logic [7:0]  str_exp [4] = '{8'h7F, 8'h80, 8'h81, 8'h82};
  logic [26:0] str_sm  [4] = '{27'h400_0000, 27'h200_0000, 27'h100_0000, 27'h080_0000};

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    op_a = '0; op_b = '0; sub = 1'b0;
    #12;
    check("rst.out_valid", 32'(out_valid), 32'd0);
    check("rst.in_ready",  32'(in_ready),  32'd1);
    check_out("rst", 8'h00, 27'h0, 27'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk) rst_n = 1'b1;

    run_one("t1", 32'h3F80_0000, 32'h4000_0000, 1'b0);
    check_out("t1", 8'h80, 27'h400_0000, 27'h200_0000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    run_one("t2a", 32'h4B80_0000, 32'h3F80_0000, 1'b0);
    check_out("t2a", 8'h97, 27'h400_0000, 27'h000_0004, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    run_one("t2b", 32'h4E80_0000, 32'h3F80_0000, 1'b0);
    check_out("t2b", 8'h9D, 27'h400_0000, 27'h000_0001, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    run_one("t2c", 32'h4B80_0000, 32'h3F80_0001, 1'b0);
    check_out("t2c", 8'h97, 27'h400_0000, 27'h000_0005, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    run_one("t3a", 32'h3F80_0000, 32'h3F80_0000, 1'b1);
    check_out("t3a", 8'h7F, 27'h400_0000, 27'h400_0000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    run_one("t3b", 32'h0000_0001, 32'h0000_0000, 1'b0);
    check_out("t3b", 8'h01, 27'h000_0008, 27'h000_0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    run_one("t3c", 32'hC040_0000, 32'h3F80_0000, 1'b0);
    check_out("t3c", 8'h80, 27'h600_0000, 27'h200_0000, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    run_one("t3d", 32'hBF80_0000, 32'h4000_0000, 1'b1);
    check_out("t3d", 8'h80, 27'h400_0000, 27'h200_0000, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    run_one("t4a", 32'h7FC0_0000, 32'h3F80_0000, 1'b0);
    check_out("t4a", 8'hFF, 27'h600_0000, 27'h000_0001, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    run_one("t4b", 32'h7F80_0000, 32'h7F80_0000, 1'b1);
    check_out("t4b", 8'hFF, 27'h400_0000, 27'h400_0000, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    run_one("t4c", 32'h7F80_0000, 32'h3F80_0000, 1'b0);
    check_out("t4c", 8'hFF, 27'h400_0000, 27'h000_0001, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

    // Backpressure stream: out_ready held low for the first 3 cycles.
    @(negedge clk);
    out_ready = 1'b0;
    fork
      begin : producer
        int accepted = 0;
        bit stall_seen = 1'b0;
        for (int i = 0; i < 4; i++) begin
          int guard = 0;
          @(negedge clk);
          op_a = str_a[i]; op_b = 32'h3F80_0000; sub = 1'b0; in_valid = 1'b1;
          while (!in_ready && guard < 20) begin
            if (!stall_seen) begin
              stall_seen = 1'b1;
              check("t5.stall_after", accepted, 32'd2);
            end
            @(negedge clk);
            guard++;
          end
          check($sformatf("t5.accept%0d", i), 32'(in_ready), 32'd1);
          @(posedge clk);
          accepted++;
          #1 in_valid = 1'b0;
        end
        check("t5.stall_seen", 32'(stall_seen), 32'd1);
      end
      begin : consumer
        int n_got = 0;
        bit held = 1'b0;
        logic [7:0]  h_exp;
        logic [26:0] h_sm;
        for (int cyc = 0; cyc < 40 && n_got < 4; cyc++) begin
          @(posedge clk);
          #1 out_ready = (cyc >= 3);
          @(negedge clk);
          if (out_valid) begin
            if (!out_ready) begin
              if (held) begin
                check("t5.hold_exp", 32'(exp_max), 32'(h_exp));
                check("t5.hold_sm",  32'(mant_small), 32'(h_sm));
              end
              held = 1'b1; h_exp = exp_max; h_sm = mant_small;
            end else if (n_got < 4) begin
              check($sformatf("t5.exp%0d", n_got), 32'(exp_max), 32'(str_exp[n_got]));
              check($sformatf("t5.sm%0d", n_got), 32'(mant_small), 32'(str_sm[n_got]));
              n_got++;
            end
          end
        end
        check("t5.count", n_got, 32'd4);
      end
    join
    repeat (3) @(negedge clk);
    check("t5.no_dup", 32'(out_valid), 32'd0);

    // Fill both stages, then reset asynchronously mid-cycle.
    out_ready = 1'b0;
    op_b = 32'h3F80_0000; sub = 1'b0;
    @(negedge clk); op_a = 32'h4000_0000; in_valid = 1'b1;
    @(negedge clk); op_a = 32'h4080_0000;
    @(posedge clk); #1 in_valid = 1'b0;
    @(negedge clk);
    check("t6.full_valid", 32'(out_valid), 32'd1);
    check("t6.full_ready", 32'(in_ready),  32'd0);
    #2 rst_n = 1'b0;
    #1;
    check("t6.rst_valid", 32'(out_valid), 32'd0);
    check("t6.rst_ready", 32'(in_ready),  32'd1);
    check_out("t6.rst", 8'h00, 27'h0, 27'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk) rst_n = 1'b1;
    check("t6.rel_ready", 32'(in_ready), 32'd1);
    run_one("t6.new", 32'h4100_0000, 32'h3F80_0000, 1'b0);
    check_out("t6.new", 8'h82, 27'h400_0000, 27'h080_0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
